// File: rtl/lsu_port.sv
// lsu_port: single-outstanding load/store initiator for one byte-addressed BRAM port.
// Checks alignment, drives the BRAM and returns an extended load result as a one-cycle response.
module lsu_port #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic              mem_wen,
    output logic              mem_b,
    output logic              mem_h,
    output logic              mem_u,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, next;
    logic we_q, uns_q;
    logic [1:0] size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, ext;
    logic accept, fault;
    assign req_ready = (state == IDLE) && !rst;
    assign accept = req_valid && req_ready;
    assign fault = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    always_comb begin
        next = state;
        next = state == IDLE  ? (accept ? (fault ? RESP : ISSUE) : IDLE) :
               state == ISSUE ? (we_q ? RESP : WAIT) :
               state == WAIT  ? RESP : IDLE;
    end
    always_comb begin
        ext = mem_dout;
        ext = size_q == 2'b00 ? (uns_q ? {24'b0, mem_dout[7:0]} : {{24{mem_dout[7]}}, mem_dout[7:0]}) :
              size_q == 2'b01 ? (uns_q ? {16'b0, mem_dout[15:0]} : {{16{mem_dout[15]}}, mem_dout[15:0]}) :
              mem_dout;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state      <= next;
            resp_valid <= next == RESP;
            if (next == RESP) begin
                // Only a direct IDLE->RESP hop is a fault; only loads arrive from WAIT.
                resp_fault <= state == IDLE;
                resp_rdata <= state == WAIT ? ext : '0;
            end
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end
    // Gating with rst drops a store whose ISSUE cycle coincides with reset.
    assign mem_wen  = (state == ISSUE) && we_q && !rst;
    assign mem_b    = size_q == 2'b00;
    assign mem_h    = size_q == 2'b01;
    assign mem_u    = uns_q;
    assign mem_addr = addr_q;
    assign mem_din  = wdata_q;
endmodule

// File: tb/tb_lsu_port.sv
// tb_lsu_port: directed tests of lsu_port against a byte-addressed BRAM model with registered read.
module tb_lsu_port;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0] req_size = 2'b00;
    logic [9:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic req_ready, resp_valid, resp_fault, mem_wen, mem_b, mem_h, mem_u;
    logic [31:0] resp_rdata, mem_din, mem_dout;
    logic [9:0] mem_addr;
    int tests = 0, fails = 0;
    int lat, np;
    logic [31:0] rd;
    logic f, wen;
    logic [7:0] m [1024] = '{default: 8'h00};
    logic [9:0] a1, a2, a3;

    lsu_port dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_wen(mem_wen),
        .mem_b(mem_b), .mem_h(mem_h), .mem_u(mem_u), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    assign a1 = mem_addr + 10'd1;
    assign a2 = mem_addr + 10'd2;
    assign a3 = mem_addr + 10'd3;
    always @(posedge clk) begin
        mem_dout <= {m[a3], m[a2], m[a1], m[mem_addr]};
        if (mem_wen) begin
            m[mem_addr] <= mem_din[7:0];
            if (!mem_b) m[a1] <= mem_din[15:8];
            if (!mem_b && !mem_h) begin
                m[a2] <= mem_din[23:16];
                m[a3] <= mem_din[31:24];
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns, input logic [9:0] a,
                          input logic [31:0] wd);
        int w;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            tests++; fails++;
            $display("FAIL accept_timeout req_ready stayed 0 for %0d cycles", w);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; np = 0; wen = 1'b0; rd = 'x; f = 1'bx;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mem_wen) wen = 1'b1;
            if (resp_valid) begin
                np++;
                if (lat == 0) begin
                    lat = i; rd = resp_rdata; f = resp_fault;
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b want 0", req_ready); end
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
        tests++; if (mem_wen !== 1'b0) begin fails++; $display("FAIL rst_mem_wen got %b want 0", mem_wen); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL idle_ready got %b want 1", req_ready); end
        tests++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
        tests++; if (resp_fault !== 1'b0) begin fails++; $display("FAIL rst_fault got %b want 0", resp_fault); end
        tests++; if (mem_addr !== 10'h0 || mem_din !== 32'h0) begin
            fails++; $display("FAIL rst_latched got addr=%h din=%h want 0/0", mem_addr, mem_din);
        end
    endtask

    task automatic test_word();
        do_req(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF);
        tests++; if (lat !== 2) begin fails++; $display("FAIL st_word_lat got %0d want 2", lat); end
        tests++; if (f !== 1'b0) begin fails++; $display("FAIL st_word_fault got %b want 0", f); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL st_word_rdata got %h want 0", rd); end
        tests++; if (wen !== 1'b1) begin fails++; $display("FAIL st_word_wen got %b want 1", wen); end
        tests++; if (np !== 1) begin fails++; $display("FAIL st_word_pulses got %0d want 1", np); end
        do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
        tests++; if (lat !== 3) begin fails++; $display("FAIL ld_word_lat got %0d want 3", lat); end
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL ld_word_rdata got %h want deadbeef", rd); end
        tests++; if (wen !== 1'b0) begin fails++; $display("FAIL ld_word_wen got %b want 0", wen); end
        tests++; if (np !== 1) begin fails++; $display("FAIL ld_word_pulses got %0d want 1", np); end
    endtask

    task automatic test_byte();
        do_req(1'b1, 2'b00, 1'b0, 10'h023, 32'h12345680);
        tests++; if (lat !== 2 || f !== 1'b0) begin fails++; $display("FAIL st_byte got lat=%0d f=%b want 2/0", lat, f); end
        do_req(1'b0, 2'b00, 1'b0, 10'h023, 32'h0);
        tests++; if (rd !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_rdata got %h want ffffff80", rd); end
        do_req(1'b0, 2'b00, 1'b1, 10'h023, 32'h0);
        tests++; if (rd !== 32'h00000080) begin fails++; $display("FAIL lbu_rdata got %h want 00000080", rd); end
        tests++; if (mem_u !== 1'b1 || mem_b !== 1'b1 || mem_h !== 1'b0) begin
            fails++; $display("FAIL lbu_flags got u=%b b=%b h=%b want 1/1/0", mem_u, mem_b, mem_h);
        end
        do_req(1'b0, 2'b10, 1'b0, 10'h020, 32'h0);
        tests++; if (rd !== 32'h80000000) begin fails++; $display("FAIL byte_only_word got %h want 80000000", rd); end
    endtask

    task automatic test_half();
        do_req(1'b1, 2'b01, 1'b0, 10'h040, 32'hFFFF8001);
        tests++; if (lat !== 2 || f !== 1'b0) begin fails++; $display("FAIL st_half got lat=%0d f=%b want 2/0", lat, f); end
        do_req(1'b0, 2'b01, 1'b0, 10'h040, 32'h0);
        tests++; if (rd !== 32'hFFFF8001) begin fails++; $display("FAIL lh_rdata got %h want ffff8001", rd); end
        do_req(1'b0, 2'b01, 1'b1, 10'h040, 32'h0);
        tests++; if (rd !== 32'h00008001) begin fails++; $display("FAIL lhu_rdata got %h want 00008001", rd); end
        do_req(1'b0, 2'b10, 1'b1, 10'h040, 32'h0);
        tests++; if (rd !== 32'h00008001) begin fails++; $display("FAIL half_only_word got %h want 00008001", rd); end
    endtask

    task automatic test_fault();
        do_req(1'b0, 2'b01, 1'b0, 10'h041, 32'h0);
        tests++; if (lat !== 1 || f !== 1'b1 || rd !== 32'h0) begin
            fails++; $display("FAIL mis_half got lat=%0d f=%b rd=%h want 1/1/0", lat, f, rd);
        end
        do_req(1'b0, 2'b10, 1'b0, 10'h042, 32'h0);
        tests++; if (lat !== 1 || f !== 1'b1 || rd !== 32'h0) begin
            fails++; $display("FAIL mis_word got lat=%0d f=%b rd=%h want 1/1/0", lat, f, rd);
        end
        do_req(1'b1, 2'b11, 1'b0, 10'h010, 32'h55555555);
        tests++; if (lat !== 1 || f !== 1'b1 || rd !== 32'h0) begin
            fails++; $display("FAIL bad_size got lat=%0d f=%b rd=%h want 1/1/0", lat, f, rd);
        end
        tests++; if (wen !== 1'b0) begin fails++; $display("FAIL fault_wen got %b want 0", wen); end
        do_req(1'b1, 2'b10, 1'b0, 10'h012, 32'h66666666);
        tests++; if (wen !== 1'b0 || f !== 1'b1) begin fails++; $display("FAIL mis_store got wen=%b f=%b want 0/1", wen, f); end
        do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
        tests++; if (rd !== 32'hDEADBEEF || f !== 1'b0) begin
            fails++; $display("FAIL after_fault got rd=%h f=%b want deadbeef/0", rd, f);
        end
    endtask

    task automatic test_reset_store();
        do_req(1'b1, 2'b10, 1'b0, 10'h3FC, 32'h11223344);
        tests++; if (lat !== 2 || f !== 1'b0) begin fails++; $display("FAIL st_3fc got lat=%0d f=%b want 2/0", lat, f); end
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 10'h3FC;
        req_wdata = 32'hAABBCCDD;
        @(posedge clk);
        #1 req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        tests++; if (mem_wen !== 1'b0) begin fails++; $display("FAIL rst_issue_wen got %b want 0", mem_wen); end
        @(posedge clk);
        #1 rst = 1'b0;
        np = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid) np++;
        end
        tests++; if (np !== 0) begin fails++; $display("FAIL dropped_resp got %0d pulses want 0", np); end
        do_req(1'b0, 2'b10, 1'b0, 10'h3FC, 32'h0);
        tests++; if (rd !== 32'h11223344) begin fails++; $display("FAIL old_3fc got %h want 11223344", rd); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] ad [3] = '{10'h010, 10'h040, 10'h020};
        logic [31:0] ex [3] = '{32'hDEADBEEF, 32'h00008001, 32'h80000000};
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            tests++; if (req_ready !== ((k % 4 == 0) ? 1'b1 : 1'b0)) begin
                fails++; $display("FAIL b2b_ready k=%0d got %b", k, req_ready);
            end
            tests++; if (resp_valid !== ((k % 4 == 3) ? 1'b1 : 1'b0)) begin
                fails++; $display("FAIL b2b_valid k=%0d got %b", k, resp_valid);
            end
            if (k % 4 == 3) begin
                tests++; if (resp_rdata !== ex[k/4]) begin
                    fails++; $display("FAIL b2b_rdata k=%0d got %h want %h", k, resp_rdata, ex[k/4]);
                end
            end
            if (k % 4 == 0) begin
                req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = ad[k/4];
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_fault();
        test_reset_store();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
